ofm_addr_gen: RTL and testbench
===============================

OFM_ADDR_GEN -- requirements
Module: ofm_addr_gen

Interface
REQ-001 SHALL have parameter SYSTOLIC_SIZE, default 16, meaning channels (addresses) emitted per write burst.
REQ-002 SHALL have parameter OFM_W, default 414, meaning output feature map width in pixels.
REQ-003 SHALL have parameter OFM_H, default 414, meaning output feature map height in pixels.
REQ-004 SHALL have parameter NUM_OUT_CH, default 32, meaning layer output channels; must be a multiple of SYSTOLIC_SIZE.
REQ-005 SHALL have parameter ADDR_WIDTH, default 24, meaning address width; must hold 2*NUM_OUT_CH*OFM_W*OFM_H-1.
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, meaning synchronous, active-high reset.
REQ-008 SHALL have port write, input, 1, meaning a one-cycle request to emit one tile burst.
REQ-009 SHALL have port addr_ready, input, 1, meaning the consumer accepts ofm_addr this cycle.
REQ-010 SHALL have port ofm_addr, output, ADDR_WIDTH, meaning the current write address.
REQ-011 SHALL have port addr_valid, output, 1, meaning ofm_addr is valid.
REQ-012 SHALL have port tile_len, output, $clog2(SYSTOLIC_SIZE+1), meaning valid pixels in the current tile, min(SYSTOLIC_SIZE, PLANE-pix_base).
REQ-013 SHALL have port layer_done, output, 1, meaning a one-cycle pulse after the last burst of the layer.
REQ-014 SHALL have port overrun, output, 1, meaning a one-cycle pulse when write arrives outside IDLE.

Function
REQ-015 SHALL define PLANE=OFM_W*OFM_H and NUM_GROUPS=NUM_OUT_CH/SYSTOLIC_SIZE.
REQ-016 SHALL implement states IDLE, BURST, ADVANCE, DONE: IDLE->BURST on write; BURST->ADVANCE on the last handshake; ADVANCE->DONE if last tile of last group, else ADVANCE->IDLE; DONE->IDLE.
REQ-017 SHALL, for write sampled in IDLE at cycle N, present addr_valid=1 with the first address at cycle N+1.
REQ-018 SHALL form address = bank_off + group*SYSTOLIC_SIZE*PLANE + ch*PLANE + pix_base, ch 0..SYSTOLIC_SIZE-1, using incremental adds of PLANE with no run-time multiplier.
REQ-019 SHALL advance ch only when addr_valid&&addr_ready, and hold ofm_addr and tile_len stable while addr_valid&&!addr_ready.
REQ-020 SHALL drive addr_valid=0 in IDLE, ADVANCE and DONE.
REQ-021 SHALL, in ADVANCE, add SYSTOLIC_SIZE to pix_base; if the result is >=PLANE, set pix_base=0 and increment group.
REQ-022 SHALL, after the last tile of group NUM_GROUPS-1, clear pix_base and group and pulse layer_done for exactly one cycle (DONE).
REQ-023 SHALL ignore write outside IDLE (no state change) and pulse overrun on the following cycle.
REQ-024 SHALL compute tile_len from pix_base, so the final tile of a group is short when PLANE mod SYSTOLIC_SIZE != 0.

Reset
REQ-025 SHALL, while rst=1 (including mid-burst), force state=IDLE, ch=0, pix_base=0, group=0, bank=0, ofm_addr=0, addr_valid=0, tile_len=0, layer_done=0, overrun=0.
REQ-026 SHALL give rst priority over write and addr_ready in the same cycle.

Configuration
REQ-027 SHALL, with OFM_ADDR_GEN_PINGPONG_EN defined, toggle bank at each layer_done, with bank_off = bank ? NUM_OUT_CH*PLANE : 0.
REQ-028 SHALL, without OFM_ADDR_GEN_PINGPONG_EN, tie bank_off to 0 and generate no bank register.

Structure
REQ-029 SHALL place the state encoding (2-bit IDLE/BURST/ADVANCE/DONE) and the PLANE/NUM_GROUPS helper constants in shared package ofm_pkg.
REQ-030 SHALL be a single module; ch/pix_base/group counting may optionally be the sub-module ofm_tile_counter.

Verification (SYSTOLIC_SIZE=4, OFM_W=OFM_H=3, NUM_OUT_CH=8, addr_ready=1 unless stated)
REQ-031 SHALL check that write in IDLE yields addresses 0,9,18,27 on four consecutive cycles starting the next cycle, tile_len=4, then addr_valid=0.
REQ-032 SHALL check that three writes yield tiles pix 4 (4,13,22,31,len 4) and pix 8 (8,17,26,35,len 1), and that a fourth write gives group 1: 36,45,54,63.
REQ-033 SHALL check that the sixth burst is followed by ADVANCE, then a single-cycle layer_done, and that the next write restarts at address 0 (72 with PINGPONG_EN).
REQ-034 SHALL check that with addr_ready low for 3 cycles at the second address, 9 holds stable with addr_valid=1, and all four addresses are still emitted exactly once.
REQ-035 SHALL check that a write during BURST pulses overrun once and leaves the address sequence unchanged.
REQ-036 SHALL check that rst at the third address of group 1 sets all outputs to 0 on the next cycle, and that the next write emits 0,9,18,27.

Source files
------------

// File: rtl/ofm_pkg.sv
// Shared definitions for the output-feature-map address generator:
// FSM state encoding and plane/group sizing helpers.
package ofm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BURST   = 2'd1,
        ST_ADVANCE = 2'd2,
        ST_DONE    = 2'd3
    } ofm_state_e;

    function automatic int plane(input int w, input int h);
        return w * h;
    endfunction

    function automatic int num_groups(input int out_ch, input int systolic);
        return out_ch / systolic;
    endfunction

endpackage

// File: rtl/ofm_addr_gen.sv
// Channel-major OFM write address generator: one burst of SYSTOLIC_SIZE addresses per write.
// Optional ping-pong output banking is enabled by defining OFM_ADDR_GEN_PINGPONG_EN.
module ofm_addr_gen
    import ofm_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = 16,
    parameter int OFM_W         = 414,
    parameter int OFM_H         = 414,
    parameter int NUM_OUT_CH    = 32,
    parameter int ADDR_WIDTH    = 24
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               write,
    input  logic                               addr_ready,
    output logic [ADDR_WIDTH-1:0]              ofm_addr,
    output logic                               addr_valid,
    output logic [$clog2(SYSTOLIC_SIZE+1)-1:0] tile_len,
    output logic                               layer_done,
    output logic                               overrun
);

    localparam int PLANE      = plane(OFM_W, OFM_H);
    localparam int NUM_GROUPS = num_groups(NUM_OUT_CH, SYSTOLIC_SIZE);
    localparam int TL_W       = $clog2(SYSTOLIC_SIZE + 1);
    localparam int CH_W       = (SYSTOLIC_SIZE > 1) ? $clog2(SYSTOLIC_SIZE) : 1;
    localparam int GRP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

    localparam logic [ADDR_WIDTH-1:0] PLANE_A    = ADDR_WIDTH'(PLANE);
    localparam logic [ADDR_WIDTH-1:0] SS_A       = ADDR_WIDTH'(SYSTOLIC_SIZE);
    localparam logic [ADDR_WIDTH-1:0] GRP_STEP_A = ADDR_WIDTH'(SYSTOLIC_SIZE * PLANE);

    ofm_state_e              state_q;
    logic [CH_W-1:0]         ch_q;
    logic [GRP_W-1:0]        group_q;
    logic [ADDR_WIDTH-1:0]   pix_base_q;
    logic [ADDR_WIDTH-1:0]   grp_base_q;
    logic [ADDR_WIDTH-1:0]   ofm_addr_q;
    logic                    addr_valid_q;
    logic [TL_W-1:0]         tile_len_q;
    logic                    layer_done_q;
    logic                    overrun_q;

    logic [ADDR_WIDTH-1:0]   bank_off;
    logic [ADDR_WIDTH-1:0]   rem_d;
    logic [ADDR_WIDTH-1:0]   pix_next_d;
    logic [ADDR_WIDTH-1:0]   start_addr_d;
    logic [TL_W-1:0]         tile_len_d;

`ifdef OFM_ADDR_GEN_PINGPONG_EN
    localparam logic [ADDR_WIDTH-1:0] BANK_A = ADDR_WIDTH'(NUM_OUT_CH * PLANE);
    logic bank_q;

    // Flip banks as the layer completes so the next layer lands in the other half.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q <= 1'b0;
        end else if (layer_done_q) begin
            bank_q <= ~bank_q;
        end
    end

    assign bank_off = bank_q ? BANK_A : '0;
`else
    assign bank_off = '0;
`endif

    // group*SYSTOLIC_SIZE*PLANE lives in grp_base_q, so no run-time multiply is needed.
    always_comb begin
        rem_d        = PLANE_A - pix_base_q;
        pix_next_d   = pix_base_q + SS_A;
        start_addr_d = bank_off + grp_base_q + pix_base_q;
        tile_len_d   = (rem_d < SS_A) ? rem_d[TL_W-1:0] : TL_W'(SYSTOLIC_SIZE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            ch_q         <= '0;
            group_q      <= '0;
            pix_base_q   <= '0;
            grp_base_q   <= '0;
            ofm_addr_q   <= '0;
            addr_valid_q <= 1'b0;
            tile_len_q   <= '0;
            layer_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            overrun_q    <= write && (state_q != ST_IDLE);
            layer_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (write) begin
                        state_q      <= ST_BURST;
                        ch_q         <= '0;
                        ofm_addr_q   <= start_addr_d;
                        tile_len_q   <= tile_len_d;
                        addr_valid_q <= 1'b1;
                    end
                end
                ST_BURST: begin
                    if (addr_valid_q && addr_ready) begin
                        if (ch_q == CH_W'(SYSTOLIC_SIZE - 1)) begin
                            ch_q         <= '0;
                            addr_valid_q <= 1'b0;
                            state_q      <= ST_ADVANCE;
                        end else begin
                            ch_q       <= ch_q + 1'b1;
                            ofm_addr_q <= ofm_addr_q + PLANE_A;
                        end
                    end
                end
                ST_ADVANCE: begin
                    if (pix_next_d >= PLANE_A) begin
                        pix_base_q <= '0;
                        if (group_q == GRP_W'(NUM_GROUPS - 1)) begin
                            group_q      <= '0;
                            grp_base_q   <= '0;
                            layer_done_q <= 1'b1;
                            state_q      <= ST_DONE;
                        end else begin
                            group_q    <= group_q + 1'b1;
                            grp_base_q <= grp_base_q + GRP_STEP_A;
                            state_q    <= ST_IDLE;
                        end
                    end else begin
                        pix_base_q <= pix_next_d;
                        state_q    <= ST_IDLE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ofm_addr   = ofm_addr_q;
    assign addr_valid = addr_valid_q;
    assign tile_len   = tile_len_q;
    assign layer_done = layer_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_ofm_addr_gen.sv
// Directed bench for ofm_addr_gen with SYSTOLIC_SIZE=4, 3x3 plane, 8 output channels.
module tb_ofm_addr_gen;

    localparam int SS  = 4;
    localparam int OW  = 3;
    localparam int OH  = 3;
    localparam int NOC = 8;
    localparam int AW  = 24;
    localparam int TLW = $clog2(SS + 1);

`ifdef OFM_ADDR_GEN_PINGPONG_EN
    localparam int RESTART = 72;
`else
    localparam int RESTART = 0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           write;
    logic           addr_ready;
    logic [AW-1:0]  ofm_addr;
    logic           addr_valid;
    logic [TLW-1:0] tile_len;
    logic           layer_done;
    logic           overrun;

    int n_cmp = 0;
    int n_bad = 0;

    ofm_addr_gen #(
        .SYSTOLIC_SIZE(SS),
        .OFM_W(OW),
        .OFM_H(OH),
        .NUM_OUT_CH(NOC),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .write(write),
        .addr_ready(addr_ready),
        .ofm_addr(ofm_addr),
        .addr_valid(addr_valid),
        .tile_len(tile_len),
        .layer_done(layer_done),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Run one burst with no checking (used only to walk the tile position forward).
    task automatic drive_burst;
        write = 1'b1;
        step();
        write = 1'b0;
        repeat (5) step();
    endtask

    task automatic test_reset;
        rst = 1'b1; write = 1'b1; addr_ready = 1'b1;
        step();
        step();
        n_cmp++;
        if ({addr_valid, ofm_addr, tile_len} !== '0) begin
            n_bad++;
            $display("FAIL reset_addr valid=%0b addr=%0d len=%0d want all 0", addr_valid, ofm_addr, tile_len);
        end
        n_cmp++;
        if ({layer_done, overrun} !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_pulses layer_done=%0b overrun=%0b want 0 0", layer_done, overrun);
        end
        rst = 1'b0; write = 1'b0;
        step();
    endtask

    task automatic test_first_burst;
        int exp_a [4] = '{0, 9, 18, 27};
        write = 1'b1;
        step();
        write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (addr_valid !== 1'b1 || ofm_addr !== AW'(exp_a[i]) || tile_len !== TLW'(4)) begin
                n_bad++;
                $display("FAIL first_burst[%0d] valid=%0b addr=%0d len=%0d want 1 %0d 4",
                         i, addr_valid, ofm_addr, tile_len, exp_a[i]);
            end
            step();
        end
        n_cmp++;
        if (addr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL first_burst_end valid=%0b want 0", addr_valid);
        end
        step();
    endtask

    task automatic test_tiles;
        int tbl [3][5] = '{'{4, 13, 22, 31, 4}, '{8, 17, 26, 35, 1}, '{36, 45, 54, 63, 4}};
        for (int t = 0; t < 3; t++) begin
            write = 1'b1;
            step();
            write = 1'b0;
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (addr_valid !== 1'b1 || ofm_addr !== AW'(tbl[t][i]) || tile_len !== TLW'(tbl[t][4])) begin
                    n_bad++;
                    $display("FAIL tiles[%0d][%0d] valid=%0b addr=%0d len=%0d want 1 %0d %0d",
                             t, i, addr_valid, ofm_addr, tile_len, tbl[t][i], tbl[t][4]);
                end
                step();
            end
            n_cmp++;
            if (addr_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL tiles_end[%0d] valid=%0b want 0", t, addr_valid);
            end
            step();
        end
    endtask

    task automatic test_overrun;
        int exp_a [4] = '{40, 49, 58, 67};
        int exp_o [4] = '{0, 0, 1, 0};
        write = 1'b1;
        step();
        write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (addr_valid !== 1'b1 || ofm_addr !== AW'(exp_a[i]) || overrun !== exp_o[i][0]) begin
                n_bad++;
                $display("FAIL overrun[%0d] valid=%0b addr=%0d overrun=%0b want 1 %0d %0d",
                         i, addr_valid, ofm_addr, overrun, exp_a[i], exp_o[i]);
            end
            write = (i == 1);
            step();
            write = 1'b0;
        end
        n_cmp++;
        if (addr_valid !== 1'b0 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_end valid=%0b overrun=%0b want 0 0", addr_valid, overrun);
        end
        step();
    endtask

    task automatic test_layer_done;
        int exp_a [4] = '{44, 53, 62, 71};
        write = 1'b1;
        step();
        write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (addr_valid !== 1'b1 || ofm_addr !== AW'(exp_a[i]) || tile_len !== TLW'(1)) begin
                n_bad++;
                $display("FAIL last_tile[%0d] valid=%0b addr=%0d len=%0d want 1 %0d 1",
                         i, addr_valid, ofm_addr, tile_len, exp_a[i]);
            end
            step();
        end
        n_cmp++;
        if (addr_valid !== 1'b0 || layer_done !== 1'b0) begin
            n_bad++;
            $display("FAIL advance valid=%0b layer_done=%0b want 0 0", addr_valid, layer_done);
        end
        step();
        n_cmp++;
        if (addr_valid !== 1'b0 || layer_done !== 1'b1) begin
            n_bad++;
            $display("FAIL done_pulse valid=%0b layer_done=%0b want 0 1", addr_valid, layer_done);
        end
        step();
        n_cmp++;
        if (layer_done !== 1'b0) begin
            n_bad++;
            $display("FAIL done_single layer_done=%0b want 0", layer_done);
        end
        write = 1'b1;
        step();
        write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (addr_valid !== 1'b1 || ofm_addr !== AW'(RESTART + 9 * i)) begin
                n_bad++;
                $display("FAIL restart[%0d] valid=%0b addr=%0d want 1 %0d",
                         i, addr_valid, ofm_addr, RESTART + 9 * i);
            end
            step();
        end
        step();
    endtask

    task automatic test_mid_reset;
        int exp_a [4] = '{0, 9, 18, 27};
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (3) drive_burst();
        write = 1'b1;
        step();
        write = 1'b0;
        step();
        step();
        n_cmp++;
        if (addr_valid !== 1'b1 || ofm_addr !== AW'(54)) begin
            n_bad++;
            $display("FAIL pre_reset valid=%0b addr=%0d want 1 54", addr_valid, ofm_addr);
        end
        rst = 1'b1;
        addr_ready = 1'b1;
        write = 1'b1;
        step();
        n_cmp++;
        if ({addr_valid, ofm_addr, tile_len, layer_done, overrun} !== '0) begin
            n_bad++;
            $display("FAIL mid_reset valid=%0b addr=%0d len=%0d done=%0b ovr=%0b want all 0",
                     addr_valid, ofm_addr, tile_len, layer_done, overrun);
        end
        rst = 1'b0;
        write = 1'b0;
        step();
        write = 1'b1;
        step();
        write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (addr_valid !== 1'b1 || ofm_addr !== AW'(exp_a[i]) || tile_len !== TLW'(4)) begin
                n_bad++;
                $display("FAIL after_reset[%0d] valid=%0b addr=%0d len=%0d want 1 %0d 4",
                         i, addr_valid, ofm_addr, tile_len, exp_a[i]);
            end
            step();
        end
        step();
    endtask

    task automatic test_backpressure;
        int exp_a [4] = '{0, 9, 18, 27};
        rst = 1'b1;
        step();
        rst = 1'b0;
        write = 1'b1;
        step();
        write = 1'b0;
        n_cmp++;
        if (addr_valid !== 1'b1 || ofm_addr !== AW'(0)) begin
            n_bad++;
            $display("FAIL bp_first valid=%0b addr=%0d want 1 0", addr_valid, ofm_addr);
        end
        step();
        addr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++;
            if (addr_valid !== 1'b1 || ofm_addr !== AW'(9) || tile_len !== TLW'(4)) begin
                n_bad++;
                $display("FAIL bp_hold[%0d] valid=%0b addr=%0d len=%0d want 1 9 4",
                         k, addr_valid, ofm_addr, tile_len);
            end
        end
        addr_ready = 1'b1;
        for (int i = 2; i < 4; i++) begin
            step();
            n_cmp++;
            if (addr_valid !== 1'b1 || ofm_addr !== AW'(exp_a[i])) begin
                n_bad++;
                $display("FAIL bp_resume[%0d] valid=%0b addr=%0d want 1 %0d", i, addr_valid, ofm_addr, exp_a[i]);
            end
        end
        step();
        n_cmp++;
        if (addr_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_end valid=%0b want 0", addr_valid);
        end
        step();
    endtask

    initial begin
        rst = 1'b1; write = 1'b0; addr_ready = 1'b1;
        test_reset();
        test_first_burst();
        test_tiles();
        test_overrun();
        test_layer_done();
        test_mid_reset();
        test_backpressure();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
